spi_peri_sync: RTL and testbench
================================

Name: spi_peri_sync

Overview:
Next-generation SPI peripheral (slave) engine, clocked entirely from the system clock. sclk, cs and mosi are oversampled through synchronisers. Supports all four SPI modes, parametrised word width, MSB/LSB-first order, full-duplex miso transmit, and back-to-back words within one cs frame. Sits between the external SPI pins and the protocol-select fabric, with valid/ready handshakes on both the rx and tx sides.

Parameters:
DATA_W, 8, bits per word (2..32)
SYNC_STAGES, 2, synchroniser flops on sclk/cs/mosi (>=2)
LSB_FIRST, 0, 1 = shift LSB first on both mosi and miso

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
mode  in  2  SPI mode; CPOL=mode[1], CPHA=mode[0]; latched at cs assertion
sclk  in  1  SPI clock (asynchronous to clk)
cs  in  1  chip select, active low
mosi  in  1  serial data in
miso  out  1  serial data out
miso_oe  out  1  miso drive enable (high while selected)
tx_data  in  DATA_W  word to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  tx holding buffer empty
rx_data  out  DATA_W  received word
rx_valid  out  1  rx_data valid, held until accepted
rx_ready  in  1  consumer accepts rx_data
rx_overrun  out  1  one-cycle pulse: word dropped
tx_underrun  out  1  one-cycle pulse: word sent with empty buffer
busy  out  1  frame in progress

Behaviour:
- Reset values: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, rx_overrun=0, tx_underrun=0, busy=0. State=IDLE. Tx buffer empty. Latched mode=0.
- Clock ratio: clk >= 8x sclk. Behaviour is undefined below that ratio.
- Synchronise sclk, cs and mosi with SYNC_STAGES flops. Then register once more for edge detection.
- Leading edge = rising if CPOL=0, else falling.
- Sample edge: leading if CPHA=0, else trailing. Shift edge is the other edge. Modes 0 and 3 therefore sample on rising, modes 1 and 2 on falling.
- FSM states: IDLE, LOAD, SHIFT, WAIT_CS.
- IDLE -> LOAD on detected cs falling edge.
- LOAD (1 cycle):
  - latch mode;
  - move the tx buffer into the tx shift register and free the buffer; if the buffer was empty, load zeros and pulse tx_underrun;
  - clear the bit counter; busy=1, miso_oe=1;
  - go to SHIFT.
- miso = tx shift register bit [DATA_W-1] (bit [0] if LSB_FIRST), registered.
- SHIFT, CPHA=0: mosi is sampled on each sample edge. The tx shift register advances on each shift edge.
- SHIFT, CPHA=1: the first leading edge of each word presents bit 0 and does not advance the register. Subsequent shift edges advance it.
- Word completion: on the DATA_W-th sample edge:
  - counter wraps to 0;
  - the assembled word goes to rx_data, with rx_valid=1 on the following clk cycle;
  - total latency from the pin edge to rx_valid is SYNC_STAGES+2 clk cycles.
- If rx_valid is still high, uncollected, at word completion: drop the new word, keep the old rx_data, pulse rx_overrun.
- rx_valid clears on the cycle after rx_valid && rx_ready. If a completion coincides with acceptance, the new word is stored and rx_valid stays 1; this is not an overrun.
- Back-to-back words: at the first shift edge after word completion, reload the tx shift register from the buffer, with the same underrun rule as LOAD.
- tx handshake: the buffer accepts tx_data on tx_valid && tx_ready. tx_ready falls the next cycle and rises the cycle after the buffer is consumed. Simultaneous consume and write is allowed: the new data is stored and tx_ready stays 0.
- cs deasserted (detected rising) in any state:
  - discard the partial word; no rx_valid, no overrun;
  - unconsumed buffer contents are retained;
  - miso_oe=0, miso=0, busy=0;
  - go to IDLE.
- Reset release with cs already low -> WAIT_CS. Ignore sclk until cs is seen high, then go to IDLE. A frame is never joined mid-way.
- Mode changes while busy are ignored until the next LOAD.
- Sclk edges in IDLE/WAIT_CS are ignored.

Decomposition:
- Package spi_pkg holds:
  - the state enum (IDLE, LOAD, SHIFT, WAIT_CS);
  - mode encodings MODE0..MODE3;
  - helper function sample_on_rise(mode).
- Sub-module spi_sync_edge: SYNC_STAGES synchroniser plus rise/fall pulse outputs. Instantiated for sclk and cs; mosi uses the synchroniser path only.

Test Plan:
- Mode 0, DATA_W=8, tx_data=0xA5 preloaded, master sends 0x3C -> rx_data=0x3C with one rx_valid; master captures 0xA5 on miso; tx_ready=1 after LOAD.
- Repeat for modes 1, 2, 3 with mosi=0xC3 and tx=0x5A -> identical data results; sampling edge verified (falling for modes 1/2).
- One cs frame, three words 0x11/0x22/0x33, rx_ready tied 1, tx refilled each word -> three rx_valid handshakes in order; miso returns all three tx words.
- rx_ready=0 across two words 0xAA then 0xBB -> rx_data stays 0xAA, single rx_overrun pulse.
- No tx_valid ever -> miso shifts 0x00, tx_underrun pulses once per word.
- cs released after 5 bits, then full frame 0x96; and rst_n pulsed mid-frame with cs low -> no rx_valid for the partial word; 0x96 received correctly; after reset, nothing is received until cs goes high then low.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types, mode encodings and helpers for the SPI
//                peripheral engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Engine control states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        SHIFT   = 2'd2,
        WAIT_CS = 2'd3
    } state_t;

    // SPI mode encodings: {CPOL, CPHA}
    localparam logic [1:0] MODE0 = 2'd0;
    localparam logic [1:0] MODE1 = 2'd1;
    localparam logic [1:0] MODE2 = 2'd2;
    localparam logic [1:0] MODE3 = 2'd3;

    // Modes 0 and 3 sample mosi on the rising sclk edge, modes 1 and 2 on falling
    function automatic logic sample_on_rise(input logic [1:0] spi_mode);
        return (spi_mode == MODE0) || (spi_mode == MODE3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sync_edge
//  Description : Multi-flop synchroniser for an asynchronous pin, followed by
//                one extra register used to produce rise/fall pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Synchroniser chain plus the delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign dout = r_sync[SYNC_STAGES-1];
    assign rise = dout & ~r_prev;
    assign fall = ~dout & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_peri_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_peri_sync
//  Description : SPI peripheral engine oversampling sclk/cs/mosi on the system
//                clock. All four modes, MSB/LSB first, full-duplex, multiple
//                words per frame, valid/ready handshakes on rx and tx.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_peri_sync
    import spi_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter bit LSB_FIRST   = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_overrun,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_t              r_state;
    state_t              w_state_nxt;

    logic                w_cs_lvl;
    logic                w_cs_rise;
    logic                w_cs_fall;
    logic                w_sclk_lvl;
    logic                w_sclk_rise;
    logic                w_sclk_fall;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                w_mosi;

    logic [1:0]          r_mode;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_rx_shift;
    logic [DATA_W-1:0]   r_tx_shift;
    logic [DATA_W-1:0]   r_tx_buf;
    logic                r_tx_full;
    logic                r_reload_pend;
    logic                r_first_hold;
    logic                r_word_done;
    logic [DATA_W-1:0]   r_rx_data;
    logic                r_rx_valid;
    logic                r_rx_overrun;
    logic                r_tx_underrun;
    logic                r_miso;

    logic                w_sclk_edge;
    logic                w_active;
    logic                w_sample;
    logic                w_shift;
    logic                w_reload;
    logic                w_consume;
    logic                w_tx_accept;
    logic [DATA_W-1:0]   w_rx_next;
    logic [DATA_W-1:0]   w_tx_adv;
    logic [DATA_W-1:0]   w_load_word;
    logic                w_tx_bit;

    // cs idles at 0 out of reset so a frame already in progress is never
    // mistaken for a fresh falling edge; IDLE then parks in WAIT_CS.
    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b0)
    ) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (cs),
        .dout  (w_cs_lvl),
        .rise  (w_cs_rise),
        .fall  (w_cs_fall)
    );

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b0)
    ) u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sclk),
        .dout  (w_sclk_lvl),
        .rise  (w_sclk_rise),
        .fall  (w_sclk_fall)
    );

    // mosi synchroniser, same depth as sclk so data and edge stay aligned
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    // An edge is a sample edge when the new sclk level matches the sampling polarity
    assign w_sclk_edge = w_sclk_rise | w_sclk_fall;
    assign w_active    = (r_state == SHIFT) && !w_cs_rise;
    assign w_sample    = w_active && w_sclk_edge && (w_sclk_lvl == sample_on_rise(r_mode));
    assign w_shift     = w_active && w_sclk_edge && (w_sclk_lvl != sample_on_rise(r_mode));
    assign w_reload    = w_shift && r_reload_pend;
    assign w_consume   = (r_state == LOAD) || w_reload;
    assign w_tx_accept = tx_valid && !r_tx_full;

    assign w_rx_next   = LSB_FIRST ? {w_mosi, r_rx_shift[DATA_W-1:1]}
                                   : {r_rx_shift[DATA_W-2:0], w_mosi};
    assign w_tx_adv    = LSB_FIRST ? {1'b0, r_tx_shift[DATA_W-1:1]}
                                   : {r_tx_shift[DATA_W-2:0], 1'b0};
    assign w_tx_bit    = LSB_FIRST ? r_tx_shift[0] : r_tx_shift[DATA_W-1];
    assign w_load_word = r_tx_full ? r_tx_buf : '0;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; cs deassertion returns to IDLE from anywhere
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = LOAD;
                end else if (!w_cs_lvl) begin
                    w_state_nxt = WAIT_CS;
                end
            end
            LOAD:    w_state_nxt = SHIFT;
            SHIFT:   w_state_nxt = SHIFT;
            WAIT_CS: w_state_nxt = WAIT_CS;
            default: w_state_nxt = IDLE;
        endcase
        if (w_cs_rise) begin
            w_state_nxt = IDLE;
        end
    end

    // Mode is captured only at frame start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode <= MODE0;
        end else if (r_state == LOAD) begin
            r_mode <= mode;
        end
    end

    // Tx holding buffer: write from fabric, drain into the shift register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx_buf      <= '0;
            r_tx_full     <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            if (w_tx_accept) begin
                r_tx_buf  <= tx_data;
                r_tx_full <= 1'b1;
            end else if (w_consume) begin
                r_tx_full <= 1'b0;
            end
            r_tx_underrun <= w_consume && !r_tx_full;
        end
    end

    // Bit counter and shift registers for both directions
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_rx_shift    <= '0;
            r_tx_shift    <= '0;
            r_reload_pend <= 1'b0;
            r_first_hold  <= 1'b0;
            r_word_done   <= 1'b0;
        end else begin
            r_word_done <= w_sample && (r_cnt == LAST_BIT);
            if (r_state == LOAD) begin
                r_tx_shift    <= w_load_word;
                r_cnt         <= '0;
                r_reload_pend <= 1'b0;
                // CPHA=1: the first leading edge only presents the already-loaded bit
                r_first_hold  <= mode[0];
            end else if (w_active) begin
                if (w_sample) begin
                    r_rx_shift <= w_rx_next;
                    if (r_cnt == LAST_BIT) begin
                        r_cnt         <= '0;
                        r_reload_pend <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                if (w_shift) begin
                    if (r_reload_pend) begin
                        r_tx_shift    <= w_load_word;
                        r_reload_pend <= 1'b0;
                        r_first_hold  <= 1'b0;
                    end else if (r_first_hold) begin
                        r_first_hold <= 1'b0;
                    end else begin
                        r_tx_shift <= w_tx_adv;
                    end
                end
            end else begin
                r_cnt         <= '0;
                r_tx_shift    <= '0;
                r_reload_pend <= 1'b0;
                r_first_hold  <= 1'b0;
            end
        end
    end

    // Rx output register with overrun detection and ready/valid handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else begin
            r_rx_overrun <= 1'b0;
            if (r_word_done) begin
                if (r_rx_valid && !rx_ready) begin
                    r_rx_overrun <= 1'b1;
                end else begin
                    r_rx_data  <= r_rx_shift;
                    r_rx_valid <= 1'b1;
                end
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    // Registered miso, forced low outside an active frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_miso <= 1'b0;
        end else begin
            r_miso <= (r_state == SHIFT) ? w_tx_bit : 1'b0;
        end
    end

    assign miso        = r_miso;
    assign miso_oe     = (r_state == LOAD) || (r_state == SHIFT);
    assign busy        = (r_state == LOAD) || (r_state == SHIFT);
    assign tx_ready    = !r_tx_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign rx_overrun  = r_rx_overrun;
    assign tx_underrun = r_tx_underrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_peri_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_peri_sync
//  Description : Directed self-checking bench for spi_peri_sync acting as an
//                SPI master on the pins and as fabric on the handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_peri_sync;

    localparam int HALF = 80;   // half sclk period: 8 clk cycles

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic       sclk;
    logic       cs;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_overrun;
    logic       tx_underrun;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_ovr    = 0;
    int n_unr    = 0;
    logic [7:0] rx_log[$];

    spi_peri_sync #(
        .DATA_W      (8),
        .SYNC_STAGES (2),
        .LSB_FIRST   (1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .sclk        (sclk),
        .cs          (cs),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_overrun  (rx_overrun),
        .tx_underrun (tx_underrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Fabric-side monitors: handshakes and pulse counts
    always @(posedge clk) begin
        if (rx_valid && rx_ready) rx_log.push_back(rx_data);
        if (rx_overrun)  n_ovr <= n_ovr + 1;
        if (tx_underrun) n_unr <= n_unr + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_tx(input logic [7:0] v);
        check("tx_ready_before_write", tx_ready, 1);
        tx_data  = v;
        tx_valid = 1'b1;
        #10;
        tx_valid = 1'b0;
        check("tx_ready_after_write", tx_ready, 0);
    endtask

    task automatic accept_rx();
        rx_ready = 1'b1;
        #10;
        rx_ready = 1'b0;
        check("rx_valid_after_accept", rx_valid, 0);
    endtask

    task automatic frame_start(input logic [1:0] m);
        mode = m;
        sclk = m[1];
        #HALF;
        cs = 1'b0;
        #HALF;
    endtask

    task automatic frame_end();
        #HALF;
        cs = 1'b1;
        #(2 * HALF);
    endtask

    // Master shifts nbits of word MSB first; ends at the final trailing edge
    task automatic xfer(input logic [1:0] m, input logic [7:0] word, input int nbits,
                        output logic [7:0] got);
        logic cpol;
        logic cpha;
        int   i;
        cpol = m[1];
        cpha = m[0];
        got  = 8'h00;
        for (int k = 0; k < nbits; k++) begin
            i = 7 - k;
            if (!cpha) begin
                mosi = word[i];
                #HALF;
                sclk   = ~cpol;
                got[i] = miso;
                #HALF;
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = word[i];
                #HALF;
                sclk   = cpol;
                got[i] = miso;
                if (k != nbits - 1) #HALF;
            end
        end
    endtask

    initial begin
        logic [7:0] got;
        logic [7:0] mosi_w [3];
        logic [7:0] tx_w   [3];
        logic [7:0] got_w  [3];
        int         base;
        int         cnt0;

        rst_n    = 1'b0;
        mode     = 2'd0;
        sclk     = 1'b0;
        cs       = 1'b1;
        mosi     = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        #50;
        check("rst_miso",        miso, 0);
        check("rst_miso_oe",     miso_oe, 0);
        check("rst_tx_ready",    tx_ready, 1);
        check("rst_rx_data",     rx_data, 0);
        check("rst_rx_valid",    rx_valid, 0);
        check("rst_rx_overrun",  rx_overrun, 0);
        check("rst_tx_underrun", tx_underrun, 0);
        check("rst_busy",        busy, 0);
        rst_n = 1'b1;
        #100;

        // Mode 0 single word
        send_tx(8'hA5);
        frame_start(2'd0);
        check("m0_busy",      busy, 1);
        check("m0_miso_oe",   miso_oe, 1);
        check("m0_tx_ready",  tx_ready, 1);
        xfer(2'd0, 8'h3C, 8, got);
        check("m0_rx_valid_at_end", rx_valid, 1);
        #HALF;
        check("m0_rx_data",   rx_data, 8'h3C);
        check("m0_miso_word", got, 8'hA5);
        frame_end();
        check("m0_busy_end",    busy, 0);
        check("m0_miso_oe_end", miso_oe, 0);
        check("m0_miso_end",    miso, 0);
        accept_rx();

        // Modes 1..3 single word; CPHA=1 samples on the trailing (last) edge
        for (int m = 1; m < 4; m++) begin
            send_tx(8'h5A);
            frame_start(2'(m));
            xfer(2'(m), 8'hC3, 8, got);
            check("mode_sample_edge", rx_valid, (m == 2) ? 1 : 0);
            #HALF;
            check("mode_rx_valid",  rx_valid, 1);
            check("mode_rx_data",   rx_data, 8'hC3);
            check("mode_miso_word", got, 8'h5A);
            frame_end();
            accept_rx();
        end

        // Three back-to-back words in one frame, rx_ready tied high
        mosi_w[0] = 8'h11; mosi_w[1] = 8'h22; mosi_w[2] = 8'h33;
        tx_w[0]   = 8'hE1; tx_w[1]   = 8'hE2; tx_w[2]   = 8'hE3;
        rx_ready = 1'b1;
        base = rx_log.size();
        send_tx(tx_w[0]);
        frame_start(2'd0);
        send_tx(tx_w[1]);
        for (int w = 0; w < 3; w++) begin
            xfer(2'd0, mosi_w[w], 8, got);
            got_w[w] = got;
            #HALF;
            if (w == 0) send_tx(tx_w[2]);
        end
        frame_end();
        rx_ready = 1'b0;
        check("b2b_rx_count", rx_log.size() - base, 3);
        for (int w = 0; w < 3; w++) begin
            if (rx_log.size() > base + w) check("b2b_rx_word", rx_log[base + w], mosi_w[w]);
            check("b2b_miso_word", got_w[w], tx_w[w]);
        end

        // Overrun: second word arrives while the first is uncollected
        cnt0 = n_ovr;
        frame_start(2'd0);
        xfer(2'd0, 8'hAA, 8, got);
        #HALF;
        xfer(2'd0, 8'hBB, 8, got);
        #HALF;
        frame_end();
        check("ovr_rx_valid", rx_valid, 1);
        check("ovr_rx_data",  rx_data, 8'hAA);
        check("ovr_pulses",   n_ovr - cnt0, 1);
        accept_rx();

        // Underrun: empty buffer for two words in mode 1
        rx_ready = 1'b1;
        cnt0 = n_unr;
        frame_start(2'd1);
        xfer(2'd1, 8'h01, 8, got);
        check("unr_miso_w0", got, 8'h00);
        #HALF;
        xfer(2'd1, 8'h02, 8, got);
        check("unr_miso_w1", got, 8'h00);
        #HALF;
        frame_end();
        check("unr_pulses", n_unr - cnt0, 2);
        check("unr_rx_last", rx_log[rx_log.size() - 1], 8'h02);

        // Partial word discarded, then a full word
        base = rx_log.size();
        frame_start(2'd0);
        xfer(2'd0, 8'hFF, 5, got);
        frame_end();
        check("partial_no_rx", rx_log.size() - base, 0);
        frame_start(2'd0);
        xfer(2'd0, 8'h96, 8, got);
        #HALF;
        frame_end();
        check("full_after_partial_cnt", rx_log.size() - base, 1);
        if (rx_log.size() > base) check("full_after_partial", rx_log[base], 8'h96);

        // Reset mid-frame with cs held low: rest of the frame is ignored
        base = rx_log.size();
        frame_start(2'd0);
        xfer(2'd0, 8'hFF, 3, got);
        rst_n = 1'b0;
        #30;
        rst_n = 1'b1;
        xfer(2'd0, 8'hF0, 8, got);
        #HALF;
        check("rst_mid_busy",  busy, 0);
        check("rst_mid_no_rx", rx_log.size() - base, 0);
        frame_end();
        frame_start(2'd0);
        xfer(2'd0, 8'h5E, 8, got);
        #HALF;
        frame_end();
        check("rst_mid_next_cnt", rx_log.size() - base, 1);
        if (rx_log.size() > base) check("rst_mid_next", rx_log[base], 8'h5E);
        rx_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
